// File: rtl/alu_rr_scheduler_if.sv
// Bundles the two requester channels, the shared-ALU wiring and the response channel.
// The slave modport is the scheduler's view; master is the surrounding logic's view.
interface alu_rr_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic [5:0]       alu_flags;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_y;
  logic [5:0]       resp_flags;
  logic             resp_dz;

  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_y, alu_flags,
    output resp_valid, resp_id, resp_y, resp_flags, resp_dz,
    input  resp_ready,
    output cnt0, cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_y, alu_flags,
    input  resp_valid, resp_id, resp_y, resp_flags, resp_dz,
    output resp_ready,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin share of one external ALU between two requesters; handshake at T -> response at T+2.
// Backpressure: a stalled response holds the FSM in RESP, so neither requester is readied until it drains.
module alu_rr_scheduler #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input logic                clk,
  input logic                rst,
  alu_rr_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OPW-1:0] OP_DIV = OPW'(3);
  localparam logic [OPW-1:0] OP_MOD = OPW'(4);

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             take0;
  logic             take1;
  logic             div_zero;

  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic [OPW-1:0]   opnd_sel;
  logic             opnd_id;

  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_y_q;
  logic [5:0]       resp_flags_q;
  logic             resp_dz_q;
  logic [CNTW-1:0]  cnt0_q;
  logic [CNTW-1:0]  cnt1_q;

  // With both valid, the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign take0 = (state == IDLE) && bus.req0_valid && !grant;
  assign take1 = (state == IDLE) && bus.req1_valid && grant;

  assign div_zero = ((opnd_sel == OP_DIV) || (opnd_sel == OP_MOD)) && (opnd_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      opnd_a       <= '0;
      opnd_b       <= '0;
      opnd_sel     <= '0;
      opnd_id      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_flags_q <= '0;
      resp_dz_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            opnd_a     <= take1 ? bus.req1_a  : bus.req0_a;
            opnd_b     <= take1 ? bus.req1_b  : bus.req0_b;
            opnd_sel   <= take1 ? bus.req1_op : bus.req0_op;
            opnd_id    <= take1;
            last_grant <= take1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_y_q     <= div_zero ? '1 : bus.alu_y;
          resp_flags_q <= bus.alu_flags;
          resp_id_q    <= opnd_id;
          resp_dz_q    <= div_zero;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            if (resp_id_q) begin
              if (cnt1_q != '1) cnt1_q <= cnt1_q + CNTW'(1);
            end else begin
              if (cnt0_q != '1) cnt0_q <= cnt0_q + CNTW'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;

  assign bus.alu_a   = opnd_a;
  assign bus.alu_b   = opnd_b;
  assign bus.alu_sel = opnd_sel;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_flags = resp_flags_q;
  assign bus.resp_dz    = resp_dz_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small stand-in ALU on the alu_* wires.
module tb_alu_rr_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_scheduler_if bus ();

  alu_rr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 DIV, 4 MOD, others XOR; flags {N,Z,C,V,E,L}.
  function automatic logic [21:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] sel);
    logic [16:0] w;
    logic [15:0] y;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (sel)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[15:0]; c = w[16]; v = c ^ y[15]; end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; y = w[15:0]; c = w[16]; v = c ^ y[15]; end
      4'd2: y = a & b;
      4'd3: y = (b == 16'd0) ? 16'd0 : a / b;
      4'd4: y = (b == 16'd0) ? 16'd0 : a % b;
      default: y = a ^ b;
    endcase
    return {y, y[15], (y == 16'd0), c, v, (a == b), (a < b)};
  endfunction

  always_comb {bus.alu_y, bus.alu_flags} = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] y;
    logic [5:0]  flags;
    logic        dz;
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] op);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  // One isolated op with resp_ready=1: ready at T, EXEC at T+1, response at T+2, drained by T+3.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    set_req(v.id, 1'b1, v.a, v.b, v.op);
    #1;
    chk({tag, ".ready"}, v.id ? bus.req1_ready : bus.req0_ready, 1);
    chk({tag, ".other_ready"}, v.id ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    set_req(v.id, 1'b0, 16'd0, 16'd0, 4'd0);
    #1;
    chk({tag, ".t1_valid"}, bus.resp_valid, 0);
    chk({tag, ".alu_a"}, bus.alu_a, v.a);
    @(negedge clk);
    #1;
    chk({tag, ".t2_valid"}, bus.resp_valid, 1);
    chk({tag, ".id"}, bus.resp_id, v.id);
    chk({tag, ".y"}, bus.resp_y, v.y);
    chk({tag, ".flags"}, bus.resp_flags, v.flags);
    chk({tag, ".dz"}, bus.resp_dz, v.dz);
    if (v.id) exp_cnt1++; else exp_cnt0++;
    @(negedge clk);
    #1;
    chk({tag, ".drained"}, bus.resp_valid, 0);
    chk({tag, ".cnt0"}, bus.cnt0, exp_cnt0);
    chk({tag, ".cnt1"}, bus.cnt1, exp_cnt1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic gid;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 6'b011100, 1'b0};
    vecs[1] = '{1'b1, 16'h0003, 16'h0005, 4'd1, 16'hFFFE, 6'b101001, 1'b0};
    vecs[2] = '{1'b0, 16'h000A, 16'h0000, 4'd3, 16'hFFFF, 6'b010000, 1'b1};
    vecs[3] = '{1'b0, 16'h000A, 16'h0000, 4'd4, 16'hFFFF, 6'b010000, 1'b1};
    vecs[4] = '{1'b0, 16'h000A, 16'h0003, 4'd3, 16'h0003, 6'b000000, 1'b0};
    vecs[5] = '{1'b1, 16'hF0F0, 16'hFF00, 4'd2, 16'hF000, 6'b100001, 1'b0};
    vecs[6] = '{1'b0, 16'h0011, 16'h0005, 4'd4, 16'h0002, 6'b000000, 1'b0};
    vecs[7] = '{1'b1, 16'h0005, 16'h0000, 4'd7, 16'h0005, 6'b000000, 1'b0};

    rst = 1'b1;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
    set_req(1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.resp_valid", bus.resp_valid, 0);
    chk("reset.resp_y", bus.resp_y, 0);
    chk("reset.resp_id", bus.resp_id, 0);
    chk("reset.resp_flags", bus.resp_flags, 0);
    chk("reset.resp_dz", bus.resp_dz, 0);
    chk("reset.alu_a", bus.alu_a, 0);
    chk("reset.alu_sel", bus.alu_sel, 0);
    chk("reset.cnt0", bus.cnt0, 0);
    chk("reset.cnt1", bus.cnt1, 0);
    chk("reset.ready0", bus.req0_ready, 0);
    chk("reset.ready1", bus.req1_ready, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset clears non-zero counters; last grant returns to 1.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    chk("rst2.cnt0", bus.cnt0, 0);
    chk("rst2.cnt1", bus.cnt1, 0);

    // Both requesters continuously valid: grants must alternate 0,1,0,1.
    @(negedge clk);
    set_req(1'b0, 1'b1, 16'd1, 16'd1, 4'd0);
    set_req(1'b1, 1'b1, 16'd2, 16'd2, 4'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk($sformatf("fair%0d.wait", k), (n < 10), 1);
      chk($sformatf("fair%0d.grant", k), bus.req1_ready, k % 2);
      chk($sformatf("fair%0d.one_ready", k), bus.req0_ready & bus.req1_ready, 0);
      gid = bus.req1_ready;
      @(negedge clk);
      if (k < 2) set_req(gid, 1'b1, 16'(k + 3), 16'(k + 3), 4'd0);
      else       set_req(gid, 1'b0, 16'd0, 16'd0, 4'd0);
      #1;
      @(negedge clk);
      #1;
      chk($sformatf("fair%0d.valid", k), bus.resp_valid, 1);
      chk($sformatf("fair%0d.id", k), bus.resp_id, k % 2);
      chk($sformatf("fair%0d.y", k), bus.resp_y, 2 * (k + 1));
    end
    @(negedge clk);
    #1;
    chk("fair.cnt0", bus.cnt0, 2);
    chk("fair.cnt1", bus.cnt1, 2);

    // Response backpressure with req1 waiting.
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 16'd5, 16'd6, 4'd0);
    set_req(1'b1, 1'b1, 16'd9, 16'd4, 4'd1);
    #1;
    chk("bp.ready0", bus.req0_ready, 1);
    chk("bp.ready1", bus.req1_ready, 0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.valid", i), bus.resp_valid, 1);
      chk($sformatf("bp%0d.y", i), bus.resp_y, 16'd11);
      chk($sformatf("bp%0d.id", i), bus.resp_id, 0);
      chk($sformatf("bp%0d.readies", i), {bus.req0_ready, bus.req1_ready}, 0);
      @(negedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp.still_valid", bus.resp_valid, 1);
    @(negedge clk);
    #1;
    chk("bp.released", bus.resp_valid, 0);
    chk("bp.req1_next", bus.req1_ready, 1);
    chk("bp.cnt0", bus.cnt0, 3);
    @(negedge clk);
    set_req(1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
    @(negedge clk);
    #1;
    chk("bp.r1_id", bus.resp_id, 1);
    chk("bp.r1_y", bus.resp_y, 16'd5);
    @(negedge clk);
    #1;
    chk("bp.cnt1", bus.cnt1, 3);

    // Reset during EXEC of a req0 op: nothing emerges, req0 wins the next contest.
    set_req(1'b0, 1'b1, 16'd7, 16'd7, 4'd0);
    #1;
    chk("rexec.ready0", bus.req0_ready, 1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rexec.valid", bus.resp_valid, 0);
    chk("rexec.cnt0", bus.cnt0, 0);
    chk("rexec.cnt1", bus.cnt1, 0);
    chk("rexec.alu_a", bus.alu_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rexec.quiet%0d", i), bus.resp_valid, 0);
    end
    set_req(1'b0, 1'b1, 16'd1, 16'd2, 4'd0);
    set_req(1'b1, 1'b1, 16'd3, 16'd4, 4'd0);
    #1;
    chk("rexec.first0", bus.req0_ready, 1);
    chk("rexec.not1", bus.req1_ready, 0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
    set_req(1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
    @(negedge clk);
    #1;
    chk("rexec.resp_id", bus.resp_id, 0);
    chk("rexec.resp_y", bus.resp_y, 16'd3);
    @(negedge clk);
    #1;
    chk("rexec.cnt0_after", bus.cnt0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 16-bit combinational ALU instance between two requesters using round-robin arbitration.
- Each requester issues {a, b, op} on a valid/ready channel. The block registers the operands, drives the shared ALU for one cycle and captures result plus flags.
- Results return on a single response channel tagged with the requester ID.
- Sits between the instruction-issue logic and the ALU; the ALU is instantiated outside and wired to the alu_* ports.

Parameters:
- WIDTH, 16, operand/result width (must match ALU).
- OPW, 4, ALU selection code width.
- CNTW, 16, width of per-requester completed-op counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  OPW  requester 0 ALU selection.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  operands to shared ALU.
- alu_sel  out  OPW  selection to shared ALU.
- alu_y  in  WIDTH  ALU result.
- alu_flags  in  6  ALU flags {N,Z,C,V,E,L}.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester that issued the op.
- resp_y  out  WIDTH  result.
- resp_flags  out  6  {N,Z,C,V,E,L}.
- resp_dz  out  1  divide/modulus by zero.
- cnt0, cnt1  out  CNTW  completed responses per requester, saturating.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, any state):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - resp_valid=0; resp_id, resp_y, resp_flags, resp_dz = 0.
  - Operand regs = 0; alu_a, alu_b, alu_sel = 0; cnt0 = cnt1 = 0.
  - Any in-flight op is discarded and produces no response.
- reqN_ready is combinational: 1 only when state==IDLE and grant==N. Never more than one ready high.
- Grant in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: stay IDLE.
- IDLE, on handshake (valid & ready):
  - Capture a, b, op and id into operand regs; last_grant <= id.
  - Go to EXEC.
- alu_a/alu_b/alu_sel are driven directly from the operand regs, so they are stable throughout EXEC and RESP.
- EXEC (exactly 1 cycle):
  - Capture resp_y <= alu_y, resp_flags <= alu_flags, resp_id <= id.
  - resp_dz <= (op==3 DIVISION or op==4 MODULUS) && b==0.
  - If resp_dz, resp_y is forced to all ones (16'hFFFF); flags are taken from the ALU unchanged.
  - Set resp_valid; go to RESP.
- RESP:
  - resp_valid=1; all resp_* held stable until resp_ready.
  - On resp_ready: resp_valid<=0; cnt[id] increments, saturating at all ones; go to IDLE.
- Latency: request handshake at cycle T -> resp_valid high at T+2. Minimum 3 cycles per op at resp_ready=1.
- Requester-side rules:
  - reqN_valid must not depend on reqN_ready.
  - A requester holding valid while not granted keeps its payload stable.
- Fairness: with both requesters continuously valid and resp_ready=1, grants strictly alternate. No requester waits more than one other op.
- Unknown op codes are passed to the ALU unchanged; resp_dz=0 for them.

Test Plan:
- Reset, then req0 ADD (op 0) a=16'hFFFF b=16'h0001, resp_ready=1 -> req0_ready at T, resp_valid at T+2: id=0, y=16'h0000, N0 Z1 C1 V1 E0 L0, dz=0, cnt0=1.
- req1 SUB (op 1) a=3 b=5 -> resp id=1, y=16'hFFFE, N=1, C=1, L=1, E=0.
- req0 and req1 both valid continuously for 4 ops (ADD 1+1, 2+2, ...) -> grant order 0,1,0,1. resp_id sequence 0,1,0,1; cnt0=2, cnt1=2.
- req0 DIV (op 3) a=10 b=0, then MOD (op 4) a=10 b=0 -> both resp_dz=1, y=16'hFFFF. Then DIV a=10 b=3 -> y=3, dz=0.
- resp_ready held low 5 cycles in RESP with req1_valid high -> resp payload stable, resp_valid stays 1, req0/req1_ready stay 0. On release, the response completes and req1 is granted next cycle.
- rst pulsed for 1 cycle during EXEC -> no response issued, cnts=0. Afterwards, with both valid, requester 0 is granted first.
